// File: rtl/bcd_countdown.sv
// Multi-digit BCD down-counter with IDLE/RUN/DONE control and a one-cycle done pulse.
// Digits borrow decade-wise; load values are clamped digit-by-digit to 9.

module bcd_digit (
    input  logic [3:0] raw,
    input  logic [3:0] digit,
    input  logic       borrow,
    output logic [3:0] clamped,
    output logic [3:0] dec
);
    assign clamped = (raw > 4'd9) ? 4'd9 : raw;
    assign dec     = !borrow ? digit : ((digit == 4'd0) ? 4'd9 : digit - 4'd1);
endmodule

module bcd_countdown #(
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic                start,
    input  logic                pause,
    output logic [4*DIGITS-1:0] count,
    output logic                busy,
    output logic                zero,
    output logic                done
);
    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   reload, reload_nxt, count_nxt;
    logic [W-1:0]   sanitised, decremented;
    logic [DIGITS-1:0] borrow;
    logic           done_nxt;

    // Digit 0 always borrows; higher digits borrow only across a run of zeros below.
    assign borrow[0] = 1'b1;
    for (genvar i = 1; i < DIGITS; i++) begin : g_borrow
        assign borrow[i] = borrow[i-1] & (count[4*(i-1) +: 4] == 4'd0);
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .raw     (load_val[4*i +: 4]),
            .digit   (count[4*i +: 4]),
            .borrow  (borrow[i]),
            .clamped (sanitised[4*i +: 4]),
            .dec     (decremented[4*i +: 4])
        );
    end

    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        reload_nxt = reload;
        done_nxt   = 1'b0;
        if (load) begin
            count_nxt  = sanitised;
            reload_nxt = sanitised;
            state_nxt  = IDLE;
        end else begin
            case (state)
                IDLE: if (start) begin
                    if (count != '0) state_nxt = RUN;
                    else begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end
                end
                RUN: if (tick && !pause) begin
                    count_nxt = decremented;
                    if (count == W'(1)) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end
                end
                DONE: if (start) begin
                    count_nxt = reload;
                    if (reload != '0) state_nxt = RUN;
                    else done_nxt = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            count  <= '0;
            reload <= '0;
            busy   <= 1'b0;
            zero   <= 1'b1;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            reload <= reload_nxt;
            busy   <= (state_nxt == RUN);
            zero   <= (count_nxt == '0);
            done   <= done_nxt;
        end
    end
endmodule

// File: tb/tb_bcd_countdown.sv
// Bench for bcd_countdown: integer-valued reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.

module tb_bcd_countdown;
    localparam int D = 2;
    localparam int W = 4 * D;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] count;
    logic         busy, zero, done;

    int n_checks = 0;
    int n_err    = 0;

    bcd_countdown #(.DIGITS(D)) dut (
        .clk(clk), .rst(rst), .tick(tick), .load(load), .load_val(load_val),
        .start(start), .pause(pause), .count(count), .busy(busy),
        .zero(zero), .done(done)
    );

    always #5 clk = ~clk;

    // Reference model: plain integers, 0 = idle, 1 = running, 2 = finished.
    int m_cnt, m_rel, m_st;
    bit m_done;

    function automatic int bcd_to_int(logic [W-1:0] v);
        int r = 0, scale = 1;
        for (int i = 0; i < D; i++) begin
            int d = int'(v[4*i +: 4]);
            if (d > 9) d = 9;
            r += d * scale;
            scale *= 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] int_to_bcd(int v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt = 0; m_rel = 0; m_st = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (load) begin
                m_cnt = bcd_to_int(load_val);
                m_rel = m_cnt;
                m_st  = 0;
            end else if (m_st == 0 && start) begin
                if (m_cnt != 0) m_st = 1;
                else begin m_st = 2; m_done = 1; end
            end else if (m_st == 1 && tick && !pause) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin m_st = 2; m_done = 1; end
            end else if (m_st == 2 && start) begin
                m_cnt = m_rel;
                if (m_rel != 0) m_st = 1;
                else m_done = 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_count", 32'(count), 32'(int_to_bcd(m_cnt)));
        chk("model_busy",  32'(busy),  32'(m_st == 1));
        chk("model_zero",  32'(zero),  32'(m_cnt == 0));
        chk("model_done",  32'(done),  32'(m_done));
    end

    // Drive one cycle of inputs; returns at the following negedge.
    task automatic step(input bit ld, input logic [W-1:0] lv, input bit st,
                        input bit tk, input bit ps);
        load = ld; load_val = lv; start = st; tick = tk; pause = ps;
        @(negedge clk);
        load = 0; start = 0; tick = 0; pause = 0;
    endtask

    task automatic idle();
        step(0, '0, 0, 0, 0);
    endtask

    logic [7:0] seq [12] = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06,
                             8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};

    initial begin
        @(negedge clk);
        chk("reset_count", 32'(count), 32'h0);
        chk("reset_zero",  32'(zero),  32'h1);
        chk("reset_busy",  32'(busy),  32'h0);
        chk("reset_done",  32'(done),  32'h0);
        rst = 1;
        idle();

        // 12 down to 00
        step(1, 8'h12, 0, 0, 0);
        chk("load12", 32'(count), 32'h12);
        step(0, '0, 1, 1, 0);
        chk("start_busy", 32'(busy), 32'h1);
        chk("start_tick_ignored", 32'(count), 32'h12);
        for (int k = 0; k < 12; k++) begin
            step(0, '0, 0, 1, 0);
            chk("seq_count", 32'(count), 32'(seq[k]));
            chk("seq_done",  32'(done), 32'(k == 11));
            chk("seq_busy",  32'(busy), 32'(k != 11));
        end
        idle();
        chk("done_one_cycle", 32'(done), 32'h0);

        // Borrow chain and zero start
        step(1, 8'h10, 0, 0, 0);
        step(0, '0, 1, 0, 0);
        step(0, '0, 0, 1, 0);
        chk("borrow", 32'(count), 32'h09);
        step(1, 8'h00, 0, 0, 0);
        step(0, '0, 1, 0, 0);
        chk("zero_start_done", 32'(done), 32'h1);
        chk("zero_start_busy", 32'(busy), 32'h0);

        // Clamp
        step(1, 8'hAF, 0, 0, 0);
        chk("clamp", 32'(count), 32'h99);
        step(0, '0, 1, 0, 0);
        step(0, '0, 0, 1, 0);
        chk("clamp_dec", 32'(count), 32'h98);

        // Pause and start ignored in RUN
        step(1, 8'h05, 0, 0, 0);
        step(0, '0, 1, 0, 0);
        repeat (3) step(0, '0, 0, 1, 1);
        chk("pause_hold", 32'(count), 32'h05);
        step(0, '0, 1, 0, 0);
        chk("run_start_ignored", 32'(busy), 32'h1);
        step(0, '0, 0, 1, 0);
        chk("unpause_dec", 32'(count), 32'h04);

        // Restart from DONE, then abort by load
        step(1, 8'h03, 0, 0, 0);
        step(0, '0, 1, 0, 0);
        repeat (3) step(0, '0, 0, 1, 0);
        chk("reach_zero", 32'(count), 32'h00);
        step(0, '0, 1, 1, 0);
        chk("restart_count", 32'(count), 32'h03);
        chk("restart_busy",  32'(busy),  32'h1);
        step(0, '0, 0, 1, 0);
        step(1, 8'h07, 1, 1, 0);
        chk("abort_count", 32'(count), 32'h07);
        chk("abort_busy",  32'(busy),  32'h0);
        chk("abort_done",  32'(done),  32'h0);

        // Async reset between edges while running
        step(0, '0, 1, 0, 0);
        @(posedge clk);
        #2 rst = 0;
        #1;
        chk("async_count", 32'(count), 32'h0);
        chk("async_zero",  32'(zero),  32'h1);
        chk("async_busy",  32'(busy),  32'h0);
        chk("async_done",  32'(done),  32'h0);
        @(negedge clk);
        rst = 1;
        idle();

        // Random traffic: small load values make frequent completions likely
        for (int c = 0; c < 3000; c++) begin
            logic [W-1:0] lv;
            lv = ($urandom_range(0, 3) == 0) ? W'($urandom) : int_to_bcd($urandom_range(0, 6));
            step($urandom_range(0, 19) == 0, lv, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
